// File: rtl/dyn_reconf_pkg.sv
// Shared constants for the MMCM DRP model: register addresses, field positions, reset values.
// Optional fractional feedback decode is enabled by defining DYN_RECONF_FRAC_EN.
package dyn_reconf_pkg;

    localparam logic [6:0] AddrClkFirst = 7'h06;
    localparam logic [6:0] AddrClkLast  = 7'h15;
    localparam logic [6:0] AddrDivReg   = 7'h16;

    // Register pair index = (addr - 0x06) >> 1
    localparam int unsigned PairClkout5 = 0;
    localparam int unsigned PairClkout0 = 1;
    localparam int unsigned PairClkout1 = 2;
    localparam int unsigned PairClkout2 = 3;
    localparam int unsigned PairClkout3 = 4;
    localparam int unsigned PairClkout4 = 5;
    localparam int unsigned PairClkout6 = 6;
    localparam int unsigned PairClkfb   = 7;
    localparam int unsigned NumPairs    = 8;

    // ClkReg1 fields
    localparam int unsigned PhaseMuxLsb = 13;
    localparam int unsigned HighLsb     = 6;
    localparam int unsigned LowLsb      = 0;
    // ClkReg2 fields
    localparam int unsigned FracLsb     = 12;
    localparam int unsigned FracEnBit   = 11;
    localparam int unsigned EdgeBit     = 7;
    localparam int unsigned NoCountBit  = 6;
    localparam int unsigned DelayLsb    = 0;
    // DivReg fields
    localparam int unsigned DivEdgeBit    = 13;
    localparam int unsigned DivNoCountBit = 12;

    localparam logic [15:0] ClkReg1Rst = 16'h0041;
    localparam logic [15:0] ClkReg2Rst = 16'h0000;
    localparam logic [15:0] DivRegRst  = 16'h1041;

    // A high/low count field of zero means 64
    function automatic logic [6:0] count_val(input logic [5:0] f);
        return (f == 6'd0) ? 7'd64 : {1'b0, f};
    endfunction

endpackage

// File: rtl/dyn_reconf_clk_decode.sv
// Decodes one ClkReg1/ClkReg2 pair into divide, duty-cycle (x1000) and phase (ns).
module dyn_reconf_clk_decode
    import dyn_reconf_pkg::*;
(
    input  logic [15:0] reg1_i,
    input  logic [15:0] reg2_i,
    input  logic [31:0] vco_period_1000_i,
    output logic [31:0] divide_o,
    output logic [31:0] duty_1000_o,
    output logic [31:0] phase_o
);

    logic [31:0] high;
    logic [31:0] low;
    logic [31:0] sum;
    logic [31:0] duty_num;
    logic [63:0] phase_prod;
    logic        edge_bit;
    logic        no_count;

    always_comb begin
        high       = 32'(count_val(reg1_i[HighLsb +: 6]));
        low        = 32'(count_val(reg1_i[LowLsb +: 6]));
        edge_bit   = reg2_i[EdgeBit];
        no_count   = reg2_i[NoCountBit];
        sum        = high + low;
        // +sum in the numerator rounds the quotient to nearest
        duty_num   = (32'd2 * high + {31'b0, edge_bit}) * 32'd1000 + sum;
        phase_prod = 64'(vco_period_1000_i) *
                     64'({reg2_i[DelayLsb +: 6], reg1_i[PhaseMuxLsb +: 3]});
        phase_o    = 32'(phase_prod / 64'd8000);
        if (no_count) begin
            divide_o    = 32'd1;
            duty_1000_o = 32'd500;
        end else begin
            divide_o    = sum;
            duty_1000_o = duty_num / (sum << 1);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{reg1_i[12], reg2_i[15:8]};

endmodule

// File: rtl/dyn_reconf.sv
// MMCM DRP register file with decode of divide, duty, phase and multiplier values.
// Define DYN_RECONF_FRAC_EN to apply the CLKFBOUT fractional multiplier field.
module dyn_reconf
    import dyn_reconf_pkg::*;
(
    input  logic        DCLK,
    input  logic        RST,
    input  logic        PWRDWN,
    input  logic [31:0] vco_period_1000,
    input  logic [6:0]  DADDR,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DRDY,
    output logic [31:0] CLKOUT0_DIVIDE,
    output logic [31:0] CLKOUT1_DIVIDE,
    output logic [31:0] CLKOUT2_DIVIDE,
    output logic [31:0] CLKOUT3_DIVIDE,
    output logic [31:0] CLKOUT4_DIVIDE,
    output logic [31:0] CLKOUT5_DIVIDE,
    output logic [31:0] CLKOUT6_DIVIDE,
    output logic [31:0] CLKOUT0_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT1_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT2_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT3_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT4_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT5_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT6_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT0_PHASE,
    output logic [31:0] CLKOUT1_PHASE,
    output logic [31:0] CLKOUT2_PHASE,
    output logic [31:0] CLKOUT3_PHASE,
    output logic [31:0] CLKOUT4_PHASE,
    output logic [31:0] CLKOUT5_PHASE,
    output logic [31:0] CLKOUT6_PHASE,
    output logic [31:0] CLKFBOUT_MULT_F_1000,
    output logic [31:0] CLKFBOUT_PHASE,
    output logic [31:0] DIVCLK_DIVIDE
);

    logic [NumPairs-1:0][15:0] reg1_q;
    logic [NumPairs-1:0][15:0] reg2_q;
    logic [15:0]               div_q;
    logic [15:0]               do_q;
    logic                      drdy_q;

    logic                      in_clk;
    logic [2:0]                pair;
    logic [15:0]               rd_data;

    always_comb begin
        in_clk  = (DADDR >= AddrClkFirst) && (DADDR <= AddrClkLast);
        pair    = 3'((DADDR - AddrClkFirst) >> 1);
        rd_data = 16'h0000;
        if (in_clk) begin
            rd_data = DADDR[0] ? reg2_q[pair] : reg1_q[pair];
        end else if (DADDR == AddrDivReg) begin
            rd_data = div_q;
        end
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NumPairs); i++) begin
                reg1_q[i] <= ClkReg1Rst;
                reg2_q[i] <= ClkReg2Rst;
            end
            div_q  <= DivRegRst;
            do_q   <= 16'h0000;
            drdy_q <= 1'b1;
        end else begin
            drdy_q <= ~DEN;
            if (DEN && DWE) begin
                if (in_clk) begin
                    if (DADDR[0]) reg2_q[pair] <= DI;
                    else          reg1_q[pair] <= DI;
                end else if (DADDR == AddrDivReg) begin
                    div_q <= DI;
                end
            end else if (DEN) begin
                do_q <= rd_data;
            end
        end
    end

    assign DO   = do_q;
    assign DRDY = drdy_q;

    logic [NumPairs-1:0][31:0] dec_divide;
    logic [NumPairs-1:0][31:0] dec_duty;
    logic [NumPairs-1:0][31:0] dec_phase;

    for (genvar g = 0; g < int'(NumPairs); g++) begin : g_dec
        dyn_reconf_clk_decode u_dec (
            .reg1_i            (reg1_q[g]),
            .reg2_i            (reg2_q[g]),
            .vco_period_1000_i (vco_period_1000),
            .divide_o          (dec_divide[g]),
            .duty_1000_o       (dec_duty[g]),
            .phase_o           (dec_phase[g])
        );
    end

    assign CLKOUT0_DIVIDE = dec_divide[PairClkout0];
    assign CLKOUT1_DIVIDE = dec_divide[PairClkout1];
    assign CLKOUT2_DIVIDE = dec_divide[PairClkout2];
    assign CLKOUT3_DIVIDE = dec_divide[PairClkout3];
    assign CLKOUT4_DIVIDE = dec_divide[PairClkout4];
    assign CLKOUT5_DIVIDE = dec_divide[PairClkout5];
    assign CLKOUT6_DIVIDE = dec_divide[PairClkout6];

    assign CLKOUT0_DUTY_CYCLE_1000 = dec_duty[PairClkout0];
    assign CLKOUT1_DUTY_CYCLE_1000 = dec_duty[PairClkout1];
    assign CLKOUT2_DUTY_CYCLE_1000 = dec_duty[PairClkout2];
    assign CLKOUT3_DUTY_CYCLE_1000 = dec_duty[PairClkout3];
    assign CLKOUT4_DUTY_CYCLE_1000 = dec_duty[PairClkout4];
    assign CLKOUT5_DUTY_CYCLE_1000 = dec_duty[PairClkout5];
    assign CLKOUT6_DUTY_CYCLE_1000 = dec_duty[PairClkout6];

    assign CLKOUT0_PHASE  = dec_phase[PairClkout0];
    assign CLKOUT1_PHASE  = dec_phase[PairClkout1];
    assign CLKOUT2_PHASE  = dec_phase[PairClkout2];
    assign CLKOUT3_PHASE  = dec_phase[PairClkout3];
    assign CLKOUT4_PHASE  = dec_phase[PairClkout4];
    assign CLKOUT5_PHASE  = dec_phase[PairClkout5];
    assign CLKOUT6_PHASE  = dec_phase[PairClkout6];
    assign CLKFBOUT_PHASE = dec_phase[PairClkfb];

`ifdef DYN_RECONF_FRAC_EN
    logic [15:0] fb_reg2;
    assign fb_reg2 = reg2_q[PairClkfb];
    always_comb begin
        CLKFBOUT_MULT_F_1000 = dec_divide[PairClkfb] * 32'd1000;
        if (!fb_reg2[NoCountBit] && fb_reg2[FracEnBit]) begin
            CLKFBOUT_MULT_F_1000 = CLKFBOUT_MULT_F_1000 +
                                   32'(fb_reg2[FracLsb +: 3]) * 32'd125;
        end
    end
`else
    // Decoder already forces divide to 1 under no_count
    assign CLKFBOUT_MULT_F_1000 = dec_divide[PairClkfb] * 32'd1000;
`endif

    always_comb begin
        if (div_q[DivNoCountBit]) begin
            DIVCLK_DIVIDE = 32'd1;
        end else begin
            DIVCLK_DIVIDE = 32'(count_val(div_q[HighLsb +: 6])) +
                            32'(count_val(div_q[LowLsb +: 6]));
        end
    end

    logic unused_ok;
    assign unused_ok = ^{PWRDWN, div_q[15:14], div_q[DivEdgeBit], dec_duty[PairClkfb]};

endmodule

// File: tb/tb_dyn_reconf.sv
// Scoreboard bench for dyn_reconf: accesses push expectations, a monitor checks on DRDY low.
module tb_dyn_reconf;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        PWRDWN = 1'b0;
    logic [31:0] vco_period_1000 = 32'd32000;
    logic [6:0]  DADDR = '0;
    logic        DEN = 1'b0;
    logic        DWE = 1'b0;
    logic [15:0] DI = '0;
    logic [15:0] DO;
    logic        DRDY;
    logic [31:0] div0, div1, div2, div3, div4, div5, div6;
    logic [31:0] dut0, dut1, dut2, dut3, dut4, dut5, dut6;
    logic [31:0] ph0, ph1, ph2, ph3, ph4, ph5, ph6;
    logic [31:0] mult_f, fb_phase, divclk;

    dyn_reconf dut (
        .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco_period_1000),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .CLKOUT0_DIVIDE(div0), .CLKOUT1_DIVIDE(div1), .CLKOUT2_DIVIDE(div2),
        .CLKOUT3_DIVIDE(div3), .CLKOUT4_DIVIDE(div4), .CLKOUT5_DIVIDE(div5),
        .CLKOUT6_DIVIDE(div6),
        .CLKOUT0_DUTY_CYCLE_1000(dut0), .CLKOUT1_DUTY_CYCLE_1000(dut1),
        .CLKOUT2_DUTY_CYCLE_1000(dut2), .CLKOUT3_DUTY_CYCLE_1000(dut3),
        .CLKOUT4_DUTY_CYCLE_1000(dut4), .CLKOUT5_DUTY_CYCLE_1000(dut5),
        .CLKOUT6_DUTY_CYCLE_1000(dut6),
        .CLKOUT0_PHASE(ph0), .CLKOUT1_PHASE(ph1), .CLKOUT2_PHASE(ph2),
        .CLKOUT3_PHASE(ph3), .CLKOUT4_PHASE(ph4), .CLKOUT5_PHASE(ph5),
        .CLKOUT6_PHASE(ph6),
        .CLKFBOUT_MULT_F_1000(mult_f), .CLKFBOUT_PHASE(fb_phase), .DIVCLK_DIVIDE(divclk)
    );

    always #5 DCLK = ~DCLK;

    localparam int SelDo = 0, SelDiv0 = 1, SelDiv1 = 2, SelDiv2 = 3, SelDiv3 = 4, SelDiv5 = 5;
    localparam int SelDuty0 = 6, SelDuty1 = 7, SelDuty2 = 8, SelDuty3 = 9, SelDuty5 = 10;
    localparam int SelPh0 = 11, SelPh1 = 12, SelPh2 = 13, SelPh5 = 14;
    localparam int SelMult = 15, SelFbPh = 16, SelDivClk = 17, SelDiv4 = 18, SelNone = -1;

    typedef struct {
        string       name;
        int          sel0, sel1, sel2, sel3;
        logic [31:0] exp0, exp1, exp2, exp3;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] out_val(input int sel);
        case (sel)
            SelDo:     return {16'h0, DO};
            SelDiv0:   return div0;
            SelDiv1:   return div1;
            SelDiv2:   return div2;
            SelDiv3:   return div3;
            SelDiv4:   return div4;
            SelDiv5:   return div5;
            SelDuty0:  return dut0;
            SelDuty1:  return dut1;
            SelDuty2:  return dut2;
            SelDuty3:  return dut3;
            SelDuty5:  return dut5;
            SelPh0:    return ph0;
            SelPh1:    return ph1;
            SelPh2:    return ph2;
            SelPh5:    return ph5;
            SelMult:   return mult_f;
            SelFbPh:   return fb_phase;
            SelDivClk: return divclk;
            default:   return 32'hdead_beef;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_sel(input string name, input int sel, input logic [31:0] exp);
        if (sel != SelNone) check($sformatf("%s[sel%0d]", name, sel), out_val(sel), exp);
    endtask

    task automatic push(input string name,
                        input int s0, input logic [31:0] e0, input int s1, input logic [31:0] e1,
                        input int s2, input logic [31:0] e2, input int s3, input logic [31:0] e3);
        exp_t e;
        e.name = name;
        e.sel0 = s0; e.exp0 = e0; e.sel1 = s1; e.exp1 = e1;
        e.sel2 = s2; e.exp2 = e2; e.sel3 = s3; e.exp3 = e3;
        sb_q.push_back(e);
    endtask

    // One-cycle DRP access: DEN high across exactly one rising edge
    task automatic access(input logic [6:0] addr, input logic we, input logic [15:0] data);
        @(posedge DCLK);
        #1;
        DADDR = addr; DWE = we; DI = data; DEN = 1'b1;
        @(posedge DCLK);
        #1;
        DEN = 1'b0; DWE = 1'b0;
    endtask

    // Monitor: every access leaves DRDY low for one cycle; that is when the response is checked
    initial begin
        forever begin
            @(negedge DCLK);
            if (!RST && !DRDY) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_sel(e.name, e.sel0, e.exp0);
                    check_sel(e.name, e.sel1, e.exp1);
                    check_sel(e.name, e.sel2, e.exp2);
                    check_sel(e.name, e.sel3, e.exp3);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        repeat (2) @(posedge DCLK);
        #1;
        check("rst_do", {16'h0, DO}, 32'd0);
        check("rst_drdy", {31'b0, DRDY}, 32'd1);
        check("rst_div0", div0, 32'd2);
        check("rst_duty6", dut6, 32'd500);
        check("rst_phase3", ph3, 32'd0);
        check("rst_mult", mult_f, 32'd2000);
        check("rst_divclk", divclk, 32'd1);
        RST = 1'b0;
        @(posedge DCLK);
        #1;
        check("idle_drdy", {31'b0, DRDY}, 32'd1);

        // Handshake on the first write
        push("wr08", SelDiv0, 32'd9, SelDuty0, 32'd667, SelPh0, 32'd12, SelDo, 32'd0);
        access(7'h08, 1'b1, 16'h6183);
        check("wr_drdy_low", {31'b0, DRDY}, 32'd0);
        @(posedge DCLK);
        #1;
        check("wr_drdy_high", {31'b0, DRDY}, 32'd1);

        push("rd08", SelDo, 32'h6183, SelNone, 0, SelNone, 0, SelNone, 0);
        access(7'h08, 1'b0, 16'h0);
        push("wr0A", SelDiv1, 32'd9, SelDuty1, 32'd667, SelPh1, 32'd12, SelDo, 32'h6183);
        access(7'h0A, 1'b1, 16'h6183);
        push("wr06", SelDiv5, 32'd9, SelDuty5, 32'd667, SelPh5, 32'd12, SelDiv3, 32'd2);
        access(7'h06, 1'b1, 16'h6183);

        push("wr09", SelDiv0, 32'd1, SelDuty0, 32'd500, SelPh0, 32'd108, SelDiv1, 32'd9);
        access(7'h09, 1'b1, 16'h0043);
        push("wr0B", SelDiv1, 32'd1, SelDuty1, 32'd500, SelPh1, 32'd108, SelNone, 0);
        access(7'h0B, 1'b1, 16'h0043);
        push("wr07", SelDiv5, 32'd1, SelDuty5, 32'd500, SelPh5, 32'd108, SelNone, 0);
        access(7'h07, 1'b1, 16'h0043);
        push("rd07", SelDo, 32'h0043, SelNone, 0, SelNone, 0, SelNone, 0);
        access(7'h07, 1'b0, 16'h0);

        // Zero fields count as 64; edge bit skews duty
        push("wr0C", SelDiv2, 32'd128, SelDuty2, 32'd500, SelPh2, 32'd0, SelNone, 0);
        access(7'h0C, 1'b1, 16'h0000);
        push("wr0D", SelDiv2, 32'd128, SelDuty2, 32'd504, SelNone, 0, SelNone, 0);
        access(7'h0D, 1'b1, 16'h0080);
        push("wr0E", SelDiv3, 32'd3, SelDuty3, 32'd333, SelNone, 0, SelNone, 0);
        access(7'h0E, 1'b1, 16'h0042);

        push("wr14", SelMult, 32'd9000, SelFbPh, 32'd12, SelNone, 0, SelNone, 0);
        access(7'h14, 1'b1, 16'h6183);
        push("wr15", SelMult, 32'd1000, SelFbPh, 32'd108, SelNone, 0, SelNone, 0);
        access(7'h15, 1'b1, 16'h0043);

        push("wr16", SelDivClk, 32'd6, SelNone, 0, SelNone, 0, SelNone, 0);
        access(7'h16, 1'b1, 16'h00C3);
        push("rd16", SelDo, 32'h00C3, SelNone, 0, SelNone, 0, SelNone, 0);
        access(7'h16, 1'b0, 16'h0);
        push("rd7F", SelDo, 32'h0, SelNone, 0, SelNone, 0, SelNone, 0);
        access(7'h7F, 1'b0, 16'h0);

        // Phase follows vco_period_1000 without a clock
        @(posedge DCLK);
        #1;
        vco_period_1000 = 32'd16000;
        #1;
        check("vco_phase0", ph0, 32'd54);
        vco_period_1000 = 32'd32000;

        // Reset held across a write edge discards the write
        @(posedge DCLK);
        #1;
        DADDR = 7'h10; DWE = 1'b1; DI = 16'h6183; DEN = 1'b1; RST = 1'b1;
        @(posedge DCLK);
        #1;
        DEN = 1'b0; DWE = 1'b0; RST = 1'b0;
        check("rst_abort_div4", div4, 32'd2);
        check("rst_abort_drdy", {31'b0, DRDY}, 32'd1);

        repeat (3) @(posedge DCLK);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
